// File: rtl/fp_post_normalize.sv
// fp_post_normalize
// Post-normalization stage for the single-precision add/subtract datapath.
// Takes a raw {sign, exponent, carry+hidden+fraction} result, shifts it one
// position per cycle until the hidden bit is set, and flags zero, underflow
// (flush to zero) and overflow (saturate to infinity). One operation is in
// flight at a time; a valid/ready handshake is used on both sides.

module fp_post_normalize #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXP_W-1:0]    in_exp,
  input  logic [MAN_W+1:0]    in_mant,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_result,
  output logic                out_zero,
  output logic                out_underflow,
  output logic                out_overflow
);

  localparam int MW = MAN_W + 2;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;

  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MW-1:0]     mant_q, mant_d;

  logic [31:0]       res_q, res_d;
  logic              zero_q, zero_d;
  logic              uf_q, uf_d;
  logic              of_q, of_d;

  // Set when the SHIFT state has reached a final result this cycle.
  logic              resolve;

  logic [MW-1:0]     mant_rsh;
  logic [EXP_W-1:0]  exp_inc;

  assign mant_rsh = mant_q >> 1;
  assign exp_inc  = exp_q + EXP_ONE;

  // State register; reset abandons any operation in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, iterate in SHIFT, hold in DONE until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (resolve)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // One normalization step: capture in IDLE, then resolve or shift once per cycle in SHIFT.
  always_comb begin
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    res_d   = res_q;
    zero_d  = zero_q;
    uf_d    = uf_q;
    of_d    = of_q;
    resolve = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = in_exp;
          mant_d = in_mant;
        end
      end
      SHIFT: begin
        if (exp_q == EXP_MAX) begin
          // Exponent already saturated: infinity regardless of mantissa.
          resolve = 1'b1;
          res_d   = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
          zero_d  = 1'b0;
          uf_d    = 1'b0;
          of_d    = 1'b1;
        end else if (mant_q == '0) begin
          // Exact cancellation gives +0.
          resolve = 1'b1;
          res_d   = '0;
          zero_d  = 1'b1;
          uf_d    = 1'b0;
          of_d    = 1'b0;
        end else if (mant_q[MW-1]) begin
          // Carry out: one right shift; the dropped LSB is truncated.
          resolve = 1'b1;
          mant_d  = mant_rsh;
          exp_d   = exp_inc;
          zero_d  = 1'b0;
          uf_d    = 1'b0;
          if (exp_inc == EXP_MAX) begin
            res_d = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
            of_d  = 1'b1;
          end else begin
            res_d = {sign_q, exp_inc, mant_rsh[MAN_W-1:0]};
            of_d  = 1'b0;
          end
        end else if (mant_q[MAN_W]) begin
          // Hidden bit set: normalized.
          resolve = 1'b1;
          res_d   = {sign_q, exp_q, mant_q[MAN_W-1:0]};
          zero_d  = 1'b0;
          uf_d    = 1'b0;
          of_d    = 1'b0;
        end else if (exp_q <= EXP_ONE) begin
          // No exponent left to borrow: flush to signed zero instead of a denormal.
          resolve = 1'b1;
          res_d   = {sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
          zero_d  = 1'b0;
          uf_d    = 1'b1;
          of_d    = 1'b0;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_ONE;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and result registers; results stay put after consumption until the next resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      mant_q <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      uf_q   <= 1'b0;
      of_q   <= 1'b0;
    end else begin
      sign_q <= sign_d;
      exp_q  <= exp_d;
      mant_q <= mant_d;
      res_q  <= res_d;
      zero_q <= zero_d;
      uf_q   <= uf_d;
      of_q   <= of_d;
    end
  end

  assign out_result    = res_q;
  assign out_zero      = zero_q;
  assign out_underflow = uf_q;
  assign out_overflow  = of_q;

endmodule

// File: tb/tb_fp_post_normalize.sv
// tb_fp_post_normalize
// Directed vectors for fp_post_normalize plus hand-written sequences for
// backpressure, busy-time input, and reset in the middle of an operation.

module tb_fp_post_normalize;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_underflow;
  logic        out_overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic [31:0] res;
    logic [2:0]  flags;
    int          lat;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  fp_post_normalize #(.EXP_W(8), .MAN_W(23)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_underflow (out_underflow),
    .out_overflow  (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Offers one operand and waits for out_valid. lat is the edge index
  // (relative to the accepting edge T) at which out_valid is first sampled high.
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [24:0] m, output int lat);
    @(negedge clk);
    checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_exp   = 8'h00;
    in_mant  = 25'h0;
    checkOutput("in_ready_while_busy", {31'd0, in_ready}, 32'd0);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic checkResult(input string name, input logic [31:0] res, input logic [2:0] flags);
    checkOutput({name, "_result"}, out_result, res);
    checkOutput({name, "_flags"}, {29'd0, out_zero, out_underflow, out_overflow}, {29'd0, flags});
  endtask

  initial begin
    int lat;
    logic [31:0] held;

    // sign, exp, mant, expected result, {zero, underflow, overflow}, latency
    vecs[0]  = '{1'b0, 8'h7F, 25'h0200000, 32'h3E800000, 3'b000, 4};
    vecs[1]  = '{1'b0, 8'h7F, 25'h1800000, 32'h40400000, 3'b000, 2};
    vecs[2]  = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 3'b001, 2};
    vecs[3]  = '{1'b1, 8'h85, 25'h0000000, 32'h00000000, 3'b100, 2};
    vecs[4]  = '{1'b1, 8'h02, 25'h0000001, 32'h80000000, 3'b010, 3};
    vecs[5]  = '{1'b1, 8'hFF, 25'h0800000, 32'hFF800000, 3'b001, 2};
    vecs[6]  = '{1'b1, 8'h80, 25'h0C00000, 32'hC0400000, 3'b000, 2};
    vecs[7]  = '{1'b0, 8'h80, 25'h1FFFFFF, 32'h40FFFFFF, 3'b000, 2};
    vecs[8]  = '{1'b0, 8'h01, 25'h0400000, 32'h00000000, 3'b010, 2};
    vecs[9]  = '{1'b0, 8'h02, 25'h0400000, 32'h00800000, 3'b000, 3};
    vecs[10] = '{1'b0, 8'h7F, 25'h0000001, 32'h34000000, 3'b000, 25};
    vecs[11] = '{1'b1, 8'h7F, 25'h0800000, 32'hBF800000, 3'b000, 2};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'h00;
    in_mant   = 25'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_handshake", {30'd0, in_ready, out_valid}, 32'd2);
    checkResult("reset", 32'h0, 3'b000);

    // Back-to-back operations with out_ready held high.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].sign, vecs[i].exp, vecs[i].mant, lat);
      checkResult($sformatf("vec%0d", i), vecs[i].res, vecs[i].flags);
      checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_idle_after", i), {30'd0, in_ready, out_valid}, 32'd2);
    end

    // Backpressure: result held for 5 cycles while in_valid is offered and must be ignored.
    out_ready = 1'b0;
    applyStimulus(1'b0, 8'h7F, 25'h0200000, lat);
    checkOutput("bp_latency", lat, 4);
    held = out_result;
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_exp   = 8'h10;
    in_mant  = 25'h1234567;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_hold%0d_handshake", c), {30'd0, in_ready, out_valid}, 32'd1);
      checkResult($sformatf("bp_hold%0d", c), 32'h3E800000, 3'b000);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_handshake", {30'd0, in_ready, out_valid}, 32'd2);
    checkOutput("bp_release_result_kept", out_result, 32'h3E800000);

    // Reset during the third SHIFT cycle of a long normalization.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'h7F;
    in_mant  = 25'h0000010;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_handshake", {30'd0, in_ready, out_valid}, 32'd2);
    checkResult("rst_mid", 32'h0, 3'b000);
    applyStimulus(1'b0, 8'h7F, 25'h0800000, lat);
    checkResult("after_rst_one", 32'h3F800000, 3'b000);
    checkOutput("after_rst_latency", lat, 2);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_post_normalize.md
Name: fp_post_normalize

Overview:
- Sequential post-normalization stage directly downstream of the floating-point add/subtract datapath.
- The datapath produces a raw sign, a larger-operand exponent, and a 25-bit mantissa (carry bit plus hidden bit plus 23 fraction bits). That mantissa may carry out or have many leading zeros, because the datapath corrects at most one position.
- This block iteratively shifts the mantissa to normalized form and adjusts the exponent. It detects zero, underflow and overflow, and emits a packed IEEE-754 single-precision word over a valid/ready handshake.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored fraction width. The internal mantissa register is MAN_W+2 bits.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, upstream raw result present.
- in_ready, output, 1, block can accept a new raw result.
- in_sign, input, 1, raw sign.
- in_exp, input, EXP_W, raw biased exponent.
- in_mant, input, MAN_W+2, raw mantissa; bit MAN_W+1 is carry, bit MAN_W is hidden bit.
- out_valid, output, 1, packed result available.
- out_ready, input, 1, downstream accepts the result.
- out_result, output, 32, {sign, exponent, fraction}.
- out_zero, output, 1, result is exact zero.
- out_underflow, output, 1, result flushed to zero after exponent exhaustion.
- out_overflow, output, 1, result saturated to infinity.

Behaviour:

Reset:
- rst sampled high on a clock edge puts the block in IDLE.
- out_valid=0, out_result=0, all flags=0, internal sign/exp/mant registers=0.
- rst overrides any in-progress operation; the pending operand is discarded.

Handshake:
- in_ready=1 only in IDLE. A transfer occurs on an edge with in_valid&&in_ready.
- out_valid=1 only in DONE. The result is consumed on an edge with out_valid&&out_ready.
- out_result and flags are registered and held stable while out_valid=1 && out_ready=0.
- No acceptance occurs while busy; one operation is in flight at a time.

States:
- IDLE: on transfer, capture in_sign, in_exp, in_mant and go to SHIFT.
- SHIFT: evaluate the registers once per cycle, in this priority order:
  1. in_exp captured == all-ones: overflow; result {sign, all-ones, 0}; out_overflow=1; go to DONE.
  2. mant == 0: result all zeros (sign forced 0); out_zero=1; go to DONE.
  3. mant[MAN_W+1]=1: mant >>= 1; exp += 1. If the new exp == all-ones, apply the overflow result and flag. Go to DONE.
  4. mant[MAN_W]=1: already normalized; go to DONE.
  5. exp <= 1: underflow; result {sign, 0, 0}; out_underflow=1; go to DONE. Denormals are flushed, not produced.
  6. Otherwise: mant <<= 1; exp -= 1; stay in SHIFT.
- DONE:
  - Normal result is {sign, exp, mant[MAN_W-1:0]}; at most one flag is set.
  - On out_ready, go to IDLE. The registered outputs keep their last value, and out_valid drops to 0 in the next cycle.

Latency:
- Accept at edge T.
- A result needing k left shifts has out_valid=1 from cycle T+2+k.
- Carry-out, already-normalized, zero and overflow cases give out_valid at T+2.
- Worst case k=MAN_W gives T+25.

Width and arithmetic rules:
- Exponent arithmetic is unsigned EXP_W-bit.
- Wrap-around is prevented by the overflow check (case 3) and the underflow check (case 5).
- Truncation only; no rounding. Bits shifted out on right shift are dropped.

Boundary conditions:
- in_valid asserted during SHIFT/DONE: ignored; upstream must hold.
- out_ready held high continuously: back-to-back operations, with one IDLE cycle between results.

Test Plan:
1. Left normalize: in_sign=0, in_exp=0x7F, in_mant=0x0200000 (1.0−0.75) -> out_result=0x3E800000, no flags, out_valid at T+4.
2. Carry-out: in_exp=0x7F, in_mant=0x1800000 -> out_result=0x40400000 (3.0), out_valid at T+2. A second case, in_exp=0xFE, in_mant=0x1000000 -> out_result=0x7F800000, out_overflow=1.
3. Zero: in_sign=1, in_exp=0x85, in_mant=0 -> out_result=0x00000000, out_zero=1, out_valid at T+2.
4. Underflow: in_sign=1, in_exp=0x02, in_mant=0x0000001 -> one shift, then out_result=0x80000000, out_underflow=1, out_valid at T+3.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_result, out_valid and flags stable, in_ready=0. Raise out_ready -> in_ready=1 next cycle.
6. Reset mid-operation: accept in_mant=0x0000010, assert rst during the third SHIFT cycle -> next cycle IDLE, in_ready=1, out_valid=0, out_result=0. A following 1.0 input (0x7F, 0x0800000) -> 0x3F800000.
